fsm_path_sequencer: RTL and testbench
=====================================

// Module: fsm_path_sequencer
// PURPOSE
//  Stores a short program of 2-bit input symbols and plays it back into fsm_moore.
//  On each run it resets the FSM for one cycle, drives one symbol per clock, and
//  samples the FSM's Moore output once per symbol. It reports the number of high samples.
//  It owns fsm_moore's rstn and i_input; it replaces hand-timed bench stimulus for path coverage.
// PARAMETERS
//  DEPTH  8  symbol buffer entries (power of two, >=2)
//  AW     3  log2(DEPTH); counters are AW+1 bits
// PORTS
//  clk          in   1     system clock, all state on rising edge
//  rstn         in   1     asynchronous active-low reset
//  i_wr_en      in   1     push i_wr_data into buffer (accepted only in IDLE, not full)
//  i_wr_data    in   2     symbol to store
//  i_clr        in   1     empty buffer (IDLE only); priority over i_wr_en
//  o_full       out  1     buffer length == DEPTH
//  i_start      in   1     begin a run (IDLE only, length>0)
//  o_busy       out  1     high in RST, PLAY, FLUSH
//  o_done       out  1     one-cycle pulse in DONE
//  o_fsm_rstn   out  1     to fsm_moore rstn
//  o_fsm_input  out  2     to fsm_moore i_input
//  i_fsm_output in   1     from fsm_moore o_output
//  o_hit_cnt    out  AW+1  count of sampled high outputs in the last run
//  o_last_out   out  1     last sample taken (final FSM output of the run)
// BEHAVIOUR
//  Reset (rstn=0, async):
//   - state=IDLE; len=0; rd_ptr=0.
//   - o_hit_cnt=0, o_last_out=0, o_done=0, o_busy=0.
//   - o_fsm_input=2'b00, o_fsm_rstn=0 (combinational from rstn, so the FSM is held in reset).
//  Buffer:
//   - Write pointer = len. In IDLE with i_wr_en and !o_full, buf[len]<=i_wr_data and len++.
//   - Writes when full, or in any state other than IDLE, are dropped silently.
//   - The buffer is retained after a run, so i_start replays the same program.
//   - i_clr in IDLE sets len=0; it is ignored outside IDLE.
//  States:
//   - IDLE:
//     - i_start && len!=0 -> RST; o_hit_cnt<=0; rd_ptr<=0.
//     - i_start with len==0 is ignored: no o_done, no FSM reset.
//     - Write and start in the same cycle: the write is accepted and included in the run.
//   - RST (1 cycle): o_fsm_rstn=0; -> PLAY.
//   - PLAY (len cycles): o_fsm_input=buf[rd_ptr]; rd_ptr++; -> FLUSH after symbol len-1.
//   - FLUSH (1 cycle): o_fsm_input=2'b00; takes the last sample; -> DONE.
//   - DONE (1 cycle): o_done=1; -> IDLE.
//  Sampling:
//   - The Moore output is valid one cycle after its symbol.
//   - Sample i_fsm_output in PLAY cycles 2..len and in FLUSH: exactly len samples.
//   - Each sample: o_last_out<=sample; if sample, o_hit_cnt++. Max value is DEPTH, which fits AW+1 bits.
//  Outputs outside runs:
//   - Outside RST, o_fsm_rstn=1 (rstn high).
//   - Outside PLAY, o_fsm_input=2'b00.
//  Timing: start seen in cycle n ->
//   - RST in n+1;
//   - PLAY in n+2..n+1+len;
//   - FLUSH in n+2+len;
//   - o_done in n+3+len.
//   - o_hit_cnt and o_last_out are stable from DONE until the next accepted start.
//  Control during a run:
//   - i_start, i_wr_en and i_clr while busy or in DONE are ignored.
//   - rstn low mid-run aborts to the reset state above; the buffer is emptied (len=0).
// TESTING (bench FSM stub: out <= (in==2'b11), reset to 0)
//  - Reset: hold rstn=0 -> o_fsm_rstn=0, o_fsm_input=00, o_hit_cnt=0, o_busy=0.
//  - Load 00,11,11,01 and start -> o_fsm_rstn=0 for 1 cycle, inputs 00,11,11,01 on
//    consecutive cycles, o_done 7 cycles after start, o_hit_cnt=2, o_last_out=0.
//  - Fill 8 words of 11, then a 9th write -> o_full=1, 9th dropped; run gives o_hit_cnt=8 (4'b1000).
//  - Start with empty buffer, or start pulsed during PLAY -> ignored, no extra o_done,
//    sequence timing unchanged.
//  - Replay without reload -> identical o_hit_cnt; i_clr then start -> no run.
//  - Drop rstn during PLAY of a 4-symbol run -> immediate IDLE, o_fsm_rstn=0, len=0, o_hit_cnt=0.

Source files
------------

// File: rtl/fsm_path_sequencer.sv
// fsm_path_sequencer: stores a short program of 2-bit symbols and plays it into a
// Moore FSM. Each run does the following:
//   - holds the FSM in reset for one cycle;
//   - drives one symbol per clock;
//   - samples the FSM output once per symbol;
//   - counts the high samples.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_wr_en, i_wr_data        push a symbol into the buffer (IDLE only, not full)
//   i_clr                     empty the buffer (IDLE only, beats i_wr_en)
//   o_full                    buffer holds DEPTH symbols
//   i_start                   begin a run (IDLE only, non-empty program)
//   o_busy, o_done            run in progress / one-cycle completion pulse
//   o_fsm_rstn, o_fsm_input   drive the FSM under test
//   i_fsm_output              Moore output of the FSM under test
//   o_hit_cnt, o_last_out     high-sample count and final sample of the last run
module fsm_path_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wr_en,
  input  logic [1:0]    i_wr_data,
  input  logic          i_clr,
  output logic          o_full,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_fsm_rstn,
  output logic [1:0]    o_fsm_input,
  input  logic          i_fsm_output,
  output logic [AW:0]   o_hit_cnt,
  output logic          o_last_out
);

  typedef enum logic [2:0] {StIdle, StRst, StPlay, StFlush, StDone} state_e;

  localparam logic [AW:0] One    = (AW+1)'(1);
  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  state_e      state;
  logic [AW:0] len;
  logic [AW:0] rd_ptr;
  logic [1:0]  mem [DEPTH];

  logic wr_ok;
  logic start_ok;
  logic sample;

  assign o_full = (len == DepthC);

  // Clear has priority over write; a write in the start cycle joins the run.
  assign wr_ok    = (state == StIdle) && i_wr_en && !o_full && !i_clr;
  assign start_ok = (state == StIdle) && i_start && !i_clr && ((len != '0) || wr_ok);

  // FSM output lags its symbol by one cycle: skip the first PLAY cycle, take FLUSH.
  assign sample = ((state == StPlay) && (rd_ptr != '0)) || (state == StFlush);

  // Buffer storage needs no reset; len alone defines valid contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[len[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= StIdle;
      len        <= '0;
      rd_ptr     <= '0;
      o_hit_cnt  <= '0;
      o_last_out <= 1'b0;
    end else begin
      if (sample) begin
        o_last_out <= i_fsm_output;
        if (i_fsm_output) begin
          o_hit_cnt <= o_hit_cnt + One;
        end
      end
      unique case (state)
        StIdle: begin
          if (i_clr) begin
            len <= '0;
          end else if (wr_ok) begin
            len <= len + One;
          end
          if (start_ok) begin
            state     <= StRst;
            o_hit_cnt <= '0;
            rd_ptr    <= '0;
          end
        end
        StRst: state <= StPlay;
        StPlay: begin
          rd_ptr <= rd_ptr + One;
          if (rd_ptr == len - One) begin
            state <= StFlush;
          end
        end
        StFlush: state <= StDone;
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign o_busy      = (state == StRst) || (state == StPlay) || (state == StFlush);
  assign o_done      = (state == StDone);
  // Follows rstn combinationally so the FSM is held in reset with the sequencer.
  assign o_fsm_rstn  = rstn && (state != StRst);
  assign o_fsm_input = (state == StPlay) ? mem[rd_ptr[AW-1:0]] : 2'b00;

endmodule

// File: tb/tb_fsm_path_sequencer.sv
module tb_fsm_path_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       clr;
  logic       full;
  logic       start;
  logic       busy;
  logic       done;
  logic       fsm_rstn;
  logic [1:0] fsm_input;
  logic       fsm_output;
  logic [3:0] hit_cnt;
  logic       last_out;

  int passed = 0;
  int total  = 0;

  logic [1:0] exp_syms [8];

  always #5 clk = ~clk;

  // FSM stub: output goes high the cycle after symbol 2'b11.
  always_ff @(posedge clk or negedge fsm_rstn) begin
    if (!fsm_rstn) fsm_output <= 1'b0;
    else           fsm_output <= (fsm_input == 2'b11);
  end

  fsm_path_sequencer #(.DEPTH(8), .AW(3)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_wr_en      (wr_en),
    .i_wr_data    (wr_data),
    .i_clr        (clr),
    .o_full       (full),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_fsm_rstn   (fsm_rstn),
    .o_fsm_input  (fsm_input),
    .i_fsm_output (fsm_output),
    .o_hit_cnt    (hit_cnt),
    .o_last_out   (last_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic write_sym(input logic [1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Runs the stored program of n symbols (exp_syms) and checks timing and results.
  // glitch pulses start/write/clear during PLAY; all must be ignored.
  task automatic run(input string tag, input int n, input int exp_hit, input logic exp_last,
                     input bit glitch);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, " rst_pulse"}, 32'(fsm_rstn), 32'd0);
    chk({tag, " rst_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s sym%0d", tag, i), 32'(fsm_input), 32'(exp_syms[i]));
      chk($sformatf("%s play_rstn%0d", tag, i), 32'(fsm_rstn), 32'd1);
      if (glitch && i == 1) begin
        start = 1'b1; wr_en = 1'b1; wr_data = 2'b10; clr = 1'b1;
      end
      if (glitch && i == 2) begin
        start = 1'b0; wr_en = 1'b0; clr = 1'b0;
      end
    end
    tick();
    chk({tag, " flush_in"}, 32'(fsm_input), 32'd0);
    chk({tag, " flush_busy"}, 32'(busy), 32'd1);
    chk({tag, " flush_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " done_busy"}, 32'(busy), 32'd0);
    chk({tag, " hit"}, 32'(hit_cnt), 32'(exp_hit));
    chk({tag, " last"}, 32'(last_out), 32'(exp_last));
    tick();
    chk({tag, " done_end"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " hit_stable"}, 32'(hit_cnt), 32'(exp_hit));
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_data = 2'b00; clr = 1'b0; start = 1'b0;
    #12;
    chk("reset fsm_rstn", 32'(fsm_rstn), 32'd0);
    chk("reset fsm_input", 32'(fsm_input), 32'd0);
    chk("reset hit", 32'(hit_cnt), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    rstn = 1'b1;
    #2;
    chk("idle fsm_rstn", 32'(fsm_rstn), 32'd1);

    // Start with empty buffer: ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty start busy", 32'(busy), 32'd0);
    chk("empty start fsm_rstn", 32'(fsm_rstn), 32'd1);
    tick();
    chk("empty start done", 32'(done), 32'd0);

    // Basic program 00,11,11,01.
    exp_syms[0] = 2'b00; exp_syms[1] = 2'b11; exp_syms[2] = 2'b11; exp_syms[3] = 2'b01;
    for (int i = 0; i < 4; i++) write_sym(exp_syms[i]);
    run("basic", 4, 2, 1'b0, 1'b0);

    // Replay without reload, with start/write/clear pulsed during PLAY.
    run("replay", 4, 2, 1'b0, 1'b1);
    chk("replay full", 32'(full), 32'd0);

    // Clear then start: no run, results retained.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr start busy", 32'(busy), 32'd0);
    tick();
    chk("clr start done", 32'(done), 32'd0);
    chk("clr hit kept", 32'(hit_cnt), 32'd2);

    // Fill with 11, then a dropped 9th write.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill full%0d", i), 32'(full), 32'd0);
      write_sym(2'b11);
      exp_syms[i] = 2'b11;
    end
    chk("full set", 32'(full), 32'd1);
    write_sym(2'b00);
    chk("full after drop", 32'(full), 32'd1);
    run("full", 8, 8, 1'b1, 1'b0);

    // Write and start in the same cycle on an empty buffer.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_syms[0] = 2'b11;
    wr_en = 1'b1; wr_data = 2'b11;
    run("wr_start", 1, 1, 1'b1, 1'b0);

    // Abort during PLAY of a 4-symbol run.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) write_sym(2'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort in play", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("abort fsm_rstn", 32'(fsm_rstn), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hit", 32'(hit_cnt), 32'd0);
    chk("abort input", 32'(fsm_input), 32'd0);
    chk("abort last", 32'(last_out), 32'd0);
    #4 rstn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort len0 busy", 32'(busy), 32'd0);
    tick();
    chk("abort len0 done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
